apb_master_bridge_p: RTL
========================

Name: apb_master_bridge_p

Overview:
- Parametrised APB4 master bridge.
- Accepts single-beat read/write requests on a valid/ready front end and drives an APB bus shared by NUM_SLAVES completers.
- Adds behaviour the previous generation lacks: address decode onto one-hot PSEL, PSTRB, back-to-back transfers without an IDLE bubble, ACCESS wait-state timeout, and decode-error responses.
- Sits between the system-side request master and the APB interconnect, which muxes PREADY, PRDATA and PSLVERR back to the bridge.

Parameters:
- ADDR_W, 8, PADDR width.
- DATA_W, 8, PWDATA/PRDATA width; must be a multiple of 8.
- NUM_SLAVES, 2, number of PSEL lines, at least 1.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, timeout or decode error.
- PSEL  out  NUM_SLAVES  one-hot completer select.
- PENABLE  out  1  ACCESS phase indicator.
- PADDR  out  ADDR_W  bus address.
- PWRITE  out  1  bus direction.
- PWDATA  out  DATA_W  bus write data.
- PSTRB  out  DATA_W/8  bus strobes.
- PREADY  in  1  completer ready.
- PRDATA  in  DATA_W  completer read data.
- PSLVERR  in  1  completer error, valid only when PREADY=1.

Behaviour:
- Reset: on any PCLK edge with PRESET=1, state <= IDLE and all registered outputs <= 0.
  - Registered outputs: PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err.
  - req_ready is forced 0 while PRESET=1.
  - An in-flight transfer is dropped with no response.
- Decode:
  - SEL_W = clog2(NUM_SLAVES), minimum 1.
  - Slave index = req_addr[ADDR_W-1 -: SEL_W].
  - An index >= NUM_SLAVES is a decode error.
- States: IDLE, SETUP, ACCESS, DERR.
- req_ready = (state==IDLE) || (state==ACCESS && PREADY). Timeout-abort cycles do not accept.
- On accept of a valid-decode request:
  - Register PADDR=req_addr, PWRITE=req_write and PSEL one-hot; next state SETUP.
  - Writes: PWDATA=req_wdata, PSTRB=req_strb.
  - Reads: PWDATA=0, PSTRB=0.
- On accept of a decode-error request: next state DERR. PSEL stays 0 and the bus is untouched.
- SETUP: PENABLE=0, exactly one cycle, then ACCESS with PENABLE=1.
  - PADDR, PWRITE, PWDATA, PSTRB and PSEL are held stable from SETUP through the final ACCESS cycle.
- ACCESS, timeout counter:
  - The counter counts ACCESS cycles with PREADY=0.
  - If TIMEOUT!=0 and the count reaches TIMEOUT, the transfer completes with error.
  - Next state IDLE; PSEL and PENABLE drop.
  - The counter clears on every entry into SETUP.
- ACCESS, PREADY=1: the transfer completes.
  - Next state is SETUP, DERR or IDLE, according to the request accepted in this same cycle (or none).
  - PENABLE drops for one cycle before the next ACCESS, because SETUP always precedes ACCESS.
- DERR: one cycle, then IDLE.
- Response:
  - rsp_valid rises exactly one cycle after a completion event: ACCESS+PREADY, timeout, or the DERR cycle.
  - rsp_err = PSLVERR on a PREADY completion, and 1 on timeout or DERR.
  - rsp_rdata = PRDATA only for a read completing with PREADY=1 and PSLVERR=0; otherwise 0.
  - rsp_valid, rsp_err and rsp_rdata return to 0 on the following cycle.
  - There is no rsp_ready; the consumer must always sink responses.
- Back-to-back: completion of transfer N and acceptance of transfer N+1 occur in the same cycle.
  - rsp N is therefore presented during the SETUP (or DERR) cycle of N+1.
- Throughput: 2 cycles per zero-wait transfer.
- Latency: 3 cycles from accept to rsp_valid for a zero-wait transfer.
- PSLVERR and PRDATA are ignored whenever PREADY=0.

Decomposition:
- apb_pkg holds:
  - the state enum apb_state_e {IDLE, SETUP, ACCESS, DERR};
  - a clog2-based SEL_W helper function;
  - a response struct {err, rdata}.
- One sub-module, apb_addr_decode: combinational, parameters ADDR_W and NUM_SLAVES, outputs a one-hot sel vector and a dec_err flag.
- The FSM, timeout counter and bus/response registers stay in the top module.

Test Plan:
- Write, NUM_SLAVES=2, addr 0x85, data 0x3C, strb 1, PREADY tied 1 -> PSEL=2'b10 for 2 cycles, PENABLE high in the second; rsp_valid 3 cycles after accept with err=0, rdata=0.
- Read, addr 0x10, PREADY low 3 ACCESS cycles then high with PRDATA=0xA5 -> PADDR stable throughout; rsp_rdata=0xA5, rsp_err=0.
- Two requests held valid, the second a read to 0x90 -> no IDLE cycle between; PENABLE low exactly 1 cycle; rsp 1 pulses during the SETUP of the second.
- NUM_SLAVES=3, ADDR_W=8, addr 0xC0 -> PSEL stays 0; DERR cycle, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- TIMEOUT=4, PREADY held 0 -> PSEL and PENABLE drop after the 4th ACCESS cycle; rsp_err=1; a new request is accepted from IDLE afterwards.
- PRESET asserted in the second ACCESS wait cycle -> all outputs 0 at the next edge, no rsp_valid, and req_ready=1 once PRESET deasserts.

Source files
------------

// File: rtl/apb_master_bridge_p_pkg.sv
// Shared types for the APB master bridge.
//   apb_state_e : bridge FSM states
//   sel_w()     : width of the slave-index field taken from the top address bits
//   apb_rsp_t   : registered response payload (rdata sized for the widest bus)
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  // Widest PRDATA the response struct can carry; DATA_W must not exceed it.
  localparam int RSP_DW_MAX = 64;

  typedef struct packed {
    logic                  err;
    logic [RSP_DW_MAX-1:0] rdata;
  } apb_rsp_t;

  // A single completer still needs one index bit so the slice is never empty.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_master_bridge_p_if.sv
// Request/response front end plus APB completer-side signals of the bridge.
//   master : bridge view (consumes requests and PREADY/PRDATA/PSLVERR,
//            drives req_ready, responses and the APB request phase)
//   slave  : environment view (request source, response sink, interconnect)
interface apb_master_bridge_p_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic [ADDR_W-1:0]     PADDR;
  logic                  PWRITE;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PREADY, PRDATA, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PREADY, PRDATA, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_bridge_p_addr_decode.sv
// Combinational address decode: the top sel_w(NUM_SLAVES) address bits pick
// the completer. Indices past the last completer flag a decode error.
//   addr    : request address
//   sel     : one-hot PSEL candidate (all zero on decode error)
//   dec_err : index >= NUM_SLAVES
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int NUM_SLAVES = 2
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);
  localparam int SEL_W = sel_w(NUM_SLAVES);

  logic [SEL_W-1:0] idx;
  assign idx = addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel[i] = (int'(idx) == i);
    dec_err = (int'(idx) >= NUM_SLAVES);
  end

  // Offset bits below the index field belong to the completer, not the decode.
  if (ADDR_W > SEL_W) begin : g_lo
    logic unused_lo;
    assign unused_lo = ^addr[ADDR_W-SEL_W-1:0];
  end
endmodule

// File: rtl/apb_master_bridge_p.sv
// APB4 master bridge: single-beat valid/ready requests in, one-hot PSEL APB
// transfers out, one-cycle response pulse back.
//   PCLK, PRESET : clock, synchronous active-high reset
//   bus.master   : request front end, response pulse, APB request/completion
// Completion in ACCESS and acceptance of the next request share a cycle, so a
// zero-wait stream runs SETUP/ACCESS/SETUP/ACCESS with no IDLE bubble.
module apb_master_bridge_p
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,   // multiple of 8, at most RSP_DW_MAX
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16   // 0 disables the wait-state abort
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_p_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  req_ready;
  logic                  accept;
  logic                  timeout_hit;

  apb_addr_decode #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) u_dec (
    .addr    (bus.req_addr),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  assign req_ready   = !PRESET &&
                       ((state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY));
  assign accept      = bus.req_valid && req_ready;
  // cnt_q holds the wait cycles already seen; this cycle would be the last allowed.
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_d       = '0;

    case (state_q)
      IDLE: ;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_d.err   = bus.PSLVERR;
          if (!pwrite_q && !bus.PSLVERR) rsp_d.rdata[DATA_W-1:0] = bus.PRDATA;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DERR: begin
        rsp_valid_d = 1'b1;
        rsp_d.err   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new request overrides the post-completion IDLE target.
    if (accept) begin
      if (dec_err) begin
        state_d = DERR;
      end else begin
        state_d  = SETUP;
        psel_d   = dec_sel;
        paddr_d  = bus.req_addr;
        pwrite_d = bus.req_write;
        pwdata_d = bus.req_write ? bus.req_wdata : '0;
        pstrb_d  = bus.req_write ? bus.req_strb  : '0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_rdata = rsp_q.rdata[DATA_W-1:0];
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;

  // rdata bits above DATA_W are always zero.
  if (DATA_W < RSP_DW_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = |rsp_q.rdata[RSP_DW_MAX-1:DATA_W];
  end
endmodule
